ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, ...) to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines. It sits beside `ps2_Main` on the same pins and covers the opposite direction: `ps2_Main` receives scan codes, this block drives host commands and checks the device acknowledge. Line drive is exposed as output-enables that pull the pin low; the top level builds the tristate.

---
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives the bus through active-high pull-low enables and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT
    } state_t;

    localparam logic [19:0] LP_INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] LP_TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        r_clk_prev;
    logic [10:0] r_frame;
    logic [3:0]  r_bit;
    logic [19:0] r_cnt;
    logic        r_ack_ok;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_clk_s;
    logic        w_dat_s;
    logic        w_fall;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_bit_nx;
    logic [19:0] w_cnt_nx;
    logic        w_ack_nx;
    logic        w_done_nx;
    logic        w_err_nx;
    logic [1:0]  w_code_nx;

    assign w_clk_s  = r_clk_sync[1];
    assign w_dat_s  = r_dat_sync[1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign w_accept = tx_valid & tx_ready;
    assign tx_done  = r_done;
    assign tx_error = r_err;
    assign err_code = r_err_code;

    // Timeout window opens at REQ, where the counter is cleared.
    assign w_timeout = (r_state inside {S_REQ, S_SEND, S_ACK, S_WAIT})
                     && (r_cnt == LP_TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
            r_clk_prev <= w_clk_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        w_bit_nx   = r_bit;
        w_cnt_nx   = r_cnt + 20'd1;
        w_ack_nx   = r_ack_ok;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_code_nx  = r_err_code;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = r_cnt;
                if (w_accept) begin
                    w_state_nx = S_INHIBIT;
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_cnt == LP_INH_LAST) begin
                    w_state_nx = S_REQ;
                    w_cnt_nx   = '0;
                end
            end
            S_REQ: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                w_state_nx = S_SEND;
            end
            S_SEND: begin
                ps2_dat_oe = ~r_frame[r_bit];
                if (w_fall) begin
                    w_bit_nx = r_bit + 4'd1;
                    if (r_bit == 4'd9) begin
                        w_state_nx = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_ack_nx   = ~w_dat_s;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_clk_s && w_dat_s) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = r_ack_ok;
                    w_err_nx   = ~r_ack_ok;
                    if (!r_ack_ok) begin
                        w_code_nx = 2'b01;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // Timeout wins over any same-cycle bus event.
        if (w_timeout) begin
            w_state_nx = S_IDLE;
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
            w_done_nx  = 1'b0;
            w_err_nx   = 1'b1;
            w_code_nx  = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame    <= '1;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_ack_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            if (w_accept) begin
                r_frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
            end
            r_bit      <= w_bit_nx;
            r_cnt      <= w_cnt_nx;
            r_ack_ok   <= w_ack_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_err_code <= w_code_nx;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a device model that clocks,
// decodes the frame and answers ACK/NACK; results checked against frame rules.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_pin;
    logic       ps2_dat_pin;

    int n_vec = 0;
    int n_miss = 0;
    int n_done_tot = 0;
    int n_err_tot = 0;
    int n_inh_tot = 0;
    int n_req_tot = 0;

    assign ps2_clk_pin = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_pin = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .err_code  (err_code),
        .ps2_clk_in(ps2_clk_pin),
        .ps2_dat_in(ps2_dat_pin),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done_tot++;
        if (tx_error) n_err_tot++;
        if (busy && ps2_clk_oe && !ps2_dat_oe) n_inh_tot++;
        if (ps2_clk_oe && ps2_dat_oe) n_req_tot++;
    end

    // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [7:0] b);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic dev_wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2_dat_oe && !ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dev_edge(output logic s);
        dev_clk_low = 1'b1;
        cyc(H);
        dev_clk_low = 1'b0;
        cyc(H / 2);
        s = ps2_dat_pin;
        cyc(H - H / 2);
    endtask

    task automatic dev_xfer(input logic nack, output logic [10:0] got,
                            output logic ok);
        logic s;
        got = '0;
        dev_wait_req(ok);
        if (!ok) return;
        cyc(H);
        got[0] = ps2_dat_pin;
        for (int i = 1; i <= 10; i++) begin
            dev_edge(s);
            got[i] = s;
        end
        dev_dat_low = !nack;
        cyc(2);
        dev_clk_low = 1'b1;
        cyc(H);
        dev_clk_low = 1'b0;
        cyc(2);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_end(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_done || tx_error) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_miss++;
            $display("FAIL reset_lines: got rdy/busy/cko/dko=%b want 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
        n_vec++;
        if ({tx_done, tx_error, err_code} !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_flags: got done/err/code=%b want 0000",
                     {tx_done, tx_error, err_code});
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        n_vec++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_miss++;
            $display("FAIL idle_after_reset: got %b want 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_basic;
        logic [10:0] got;
        logic ok, seen;
        int d0, e0, i0, r0;
        d0 = n_done_tot; e0 = n_err_tot; i0 = n_inh_tot; r0 = n_req_tot;
        send_req(8'hED);
        @(negedge clk);
        n_vec++;
        if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL basic_inhibit_start: got cko=%b busy=%b want 1 1",
                     ps2_clk_oe, busy);
        end
        dev_xfer(1'b0, got, ok);
        wait_end(seen);
        cyc(3);
        n_vec++;
        if (!ok || !seen) begin
            n_miss++;
            $display("FAIL basic_handshake: got req=%b end=%b want 1 1",
                     ok, seen);
        end
        n_vec++;
        if (got !== frame_of(8'hED)) begin
            n_miss++;
            $display("FAIL basic_frame: got %b want %b", got, frame_of(8'hED));
        end
        n_vec++;
        if (n_inh_tot - i0 != INH || n_req_tot - r0 != 1) begin
            n_miss++;
            $display("FAIL basic_inhibit_len: got inh=%0d req=%0d want %0d 1",
                     n_inh_tot - i0, n_req_tot - r0, INH);
        end
        n_vec++;
        if (n_done_tot - d0 != 1 || n_err_tot - e0 != 0) begin
            n_miss++;
            $display("FAIL basic_pulses: got done=%0d err=%0d want 1 0",
                     n_done_tot - d0, n_err_tot - e0);
        end
        n_vec++;
        if (err_code !== 2'b00) begin
            n_miss++;
            $display("FAIL basic_err_code: got %b want 00", err_code);
        end
    endtask

    task automatic test_parity;
        logic [7:0] bytes[6];
        logic [10:0] got, exp;
        logic ok, seen;
        int d0;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h01;
        for (int k = 3; k < 6; k++) bytes[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            d0  = n_done_tot;
            exp = frame_of(bytes[k]);
            send_req(bytes[k]);
            dev_xfer(1'b0, got, ok);
            wait_end(seen);
            cyc(3);
            n_vec++;
            if (got !== exp || !ok) begin
                n_miss++;
                $display("FAIL parity_frame %02h: got %b want %b",
                         bytes[k], got, exp);
            end
            n_vec++;
            if (n_done_tot - d0 != 1 || !seen) begin
                n_miss++;
                $display("FAIL parity_done %02h: got %0d want 1",
                         bytes[k], n_done_tot - d0);
            end
        end
    endtask

    task automatic test_nack;
        logic [10:0] got;
        logic ok, seen;
        int d0, e0;
        d0 = n_done_tot; e0 = n_err_tot;
        send_req(8'hF4);
        dev_xfer(1'b1, got, ok);
        wait_end(seen);
        n_vec++;
        if (!seen || tx_error !== 1'b1 || err_code !== 2'b01) begin
            n_miss++;
            $display("FAIL nack_code: got err=%b code=%b want 1 01",
                     tx_error, err_code);
        end
        cyc(3);
        n_vec++;
        if (got !== frame_of(8'hF4) || !ok) begin
            n_miss++;
            $display("FAIL nack_frame: got %b want %b", got, frame_of(8'hF4));
        end
        n_vec++;
        if (n_err_tot - e0 != 1 || n_done_tot - d0 != 0) begin
            n_miss++;
            $display("FAIL nack_pulses: got err=%0d done=%0d want 1 0",
                     n_err_tot - e0, n_done_tot - d0);
        end
    endtask

    task automatic test_timeout;
        int k, d0;
        logic found;
        d0 = n_done_tot;
        send_req(8'hFF);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2_clk_oe && ps2_dat_oe) begin
                found = 1'b1;
                break;
            end
        end
        k = 0;
        if (found) begin
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                k++;
                if (tx_error) break;
            end
        end
        n_vec++;
        if (!found || k != TMO) begin
            n_miss++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", k, TMO);
        end
        n_vec++;
        if ({tx_error, err_code} !== 3'b110) begin
            n_miss++;
            $display("FAIL timeout_code: got err/code=%b want 110",
                     {tx_error, err_code});
        end
        n_vec++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_ready} !== 4'b0001) begin
            n_miss++;
            $display("FAIL timeout_release: got %b want 0001",
                     {ps2_clk_oe, ps2_dat_oe, busy, tx_ready});
        end
        cyc(3);
        n_vec++;
        if (n_done_tot - d0 != 0) begin
            n_miss++;
            $display("FAIL timeout_no_done: got %0d want 0", n_done_tot - d0);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        logic ok, seen, s;
        int d0, e0;
        d0 = n_done_tot; e0 = n_err_tot;
        send_req(8'hED);
        dev_wait_req(ok);
        cyc(H);
        for (int i = 0; i < 4; i++) dev_edge(s);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_ready} !== 4'b0001 || !ok) begin
            n_miss++;
            $display("FAIL midreset_release: got %b want 0001",
                     {ps2_clk_oe, ps2_dat_oe, busy, tx_ready});
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        n_vec++;
        if (n_done_tot != d0 || n_err_tot != e0) begin
            n_miss++;
            $display("FAIL midreset_pulses: got done=%0d err=%0d want 0 0",
                     n_done_tot - d0, n_err_tot - e0);
        end
        send_req(8'hF3);
        dev_xfer(1'b0, got, ok);
        wait_end(seen);
        cyc(3);
        n_vec++;
        if (got !== frame_of(8'hF3) || n_done_tot - d0 != 1 || !seen) begin
            n_miss++;
            $display("FAIL midreset_next: got %b done=%0d want %b 1",
                     got, n_done_tot - d0, frame_of(8'hF3));
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] got1, got2;
        logic ok1, ok2, seen;
        int d0, i0;
        d0 = n_done_tot; i0 = n_inh_tot;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hED;
        @(posedge clk);
        #1;
        tx_data = 8'hAA;
        dev_xfer(1'b0, got1, ok1);
        wait_end(seen);
        n_vec++;
        if (!seen || tx_done !== 1'b1 || tx_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_done_ready: got done=%b rdy=%b want 1 1",
                     tx_done, tx_ready);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        dev_xfer(1'b0, got2, ok2);
        wait_end(seen);
        cyc(3);
        n_vec++;
        if (got1 !== frame_of(8'hED) || !ok1) begin
            n_miss++;
            $display("FAIL b2b_first: got %b want %b", got1, frame_of(8'hED));
        end
        n_vec++;
        if (got2 !== frame_of(8'hAA) || !ok2) begin
            n_miss++;
            $display("FAIL b2b_second: got %b want %b", got2, frame_of(8'hAA));
        end
        n_vec++;
        if (n_done_tot - d0 != 2 || n_inh_tot - i0 != 2 * INH) begin
            n_miss++;
            $display("FAIL b2b_counts: got done=%0d inh=%0d want 2 %0d",
                     n_done_tot - d0, n_inh_tot - i0, 2 * INH);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
